// File: rtl/debug_ocimem_ctrl.sv
// rtl/debug_ocimem_ctrl.sv - Nios II debug OCI memory controller (JTAG + CPU arbitration)
// Define DEBUG_OCIMEM_PARITY_EN for 36-bit RAM with per-byte even parity checking.
module debug_ocimem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  input  logic              debugaccess,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

`ifdef DEBUG_OCIMEM_PARITY_EN
  localparam int RAM_W = 36;
`else
  localparam int RAM_W = 32;
`endif

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] J_RD1 = 3'd1;
  localparam logic [2:0] J_RD2 = 3'd2;
  localparam logic [2:0] J_WR  = 3'd3;
  localparam logic [2:0] C_RD1 = 3'd4;
  localparam logic [2:0] C_RD2 = 3'd5;

  logic [2:0]  state;
  logic        pend_v;
  logic        pend_wr;
  logic        pend_inc;
  logic [31:0] pend_data;
  logic        cur_inc;
  logic [31:0] cur_data;

  logic [RAM_W-1:0]  mem [0:(2**ADDR_W)-1];
  logic [RAM_W-1:0]  ram_q;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [ADDR_W-1:0] ram_raddr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_be;

  logic sb, sn, sa;
  logic collide, win_a, win_n;
  logic new_req, new_acc, drop, addr_load, err_clr;
  logic new_wr, new_inc;
  logic idle, jtag_go, wr_ack;
  logic go_wr, go_inc;
  logic [31:0] go_data;
  logic par_set;
  logic unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  // Strobe arbitration: b beats no_action_a beats action_a; any loser is an error.
  assign sb        = take_action_ocimem_b;
  assign sn        = take_no_action_ocimem_a;
  assign sa        = take_action_ocimem_a;
  assign collide   = (sb & sn) | (sb & sa) | (sn & sa);
  assign win_n     = sn & ~sb;
  assign win_a     = sa & ~sb & ~sn;
  assign new_req   = sb | win_n | (win_a & ~jdo[35] & jdo[34]);
  assign new_wr    = sb;
  assign new_inc   = win_n;
  assign new_acc   = new_req & ~pend_v;
  assign drop      = new_req & pend_v;
  assign addr_load = win_a & ~jdo[35] & (~jdo[34] | ~pend_v);
  assign err_clr   = win_a & jdo[35] & jdo[34];

  assign idle    = (state == IDLE);
  assign jtag_go = idle & (pend_v | new_acc);
  assign wr_ack  = reset_n & idle & ~jtag_go & ~read & write;
  assign waitrequest = ~((state == C_RD2) | wr_ack);

  assign go_wr   = pend_v ? pend_wr   : new_wr;
  assign go_inc  = pend_v ? pend_inc  : new_inc;
  assign go_data = pend_v ? pend_data : jdo[34:3];

  // CPU reads address the RAM from IDLE so readdata is registered by C_RD2.
  assign ram_raddr = (state == J_RD1) ? MonAReg : address;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = MonAReg;
    ram_wdata = cur_data;
    ram_be    = 4'hF;
    if (state == J_WR) begin
      ram_we = reset_n;
    end else if (wr_ack && debugaccess) begin
      ram_we    = 1'b1;
      ram_waddr = address;
      ram_wdata = writedata;
      ram_be    = byteenable;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) begin
          mem[ram_waddr][8*i +: 8] <= ram_wdata[8*i +: 8];
`ifdef DEBUG_OCIMEM_PARITY_EN
          mem[ram_waddr][32+i] <= ^ram_wdata[8*i +: 8];
`endif
        end
      end
    end
    ram_q <= mem[ram_raddr];
  end

`ifdef DEBUG_OCIMEM_PARITY_EN
  function automatic logic [3:0] byte_par(input logic [31:0] d);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

  logic par_bad;
  logic c_perr_q;
  assign par_bad = (ram_q[35:32] != byte_par(ram_q[31:0]));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) c_perr_q <= 1'b0;
    else          c_perr_q <= (state == C_RD1) & par_bad;
  end

  assign par_set = ((state == J_RD2) & par_bad) | ((state == C_RD2) & c_perr_q);
`else
  assign par_set = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      pend_v        <= 1'b0;
      pend_wr       <= 1'b0;
      pend_inc      <= 1'b0;
      pend_data     <= 32'd0;
      cur_inc       <= 1'b0;
      cur_data      <= 32'd0;
      readdata      <= 32'd0;
      MonDReg       <= 32'd0;
      MonAReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (jtag_go) begin
            state    <= go_wr ? J_WR : J_RD1;
            cur_inc  <= go_inc;
            cur_data <= go_data;
          end else if (read) begin
            state <= C_RD1;
          end
        end
        J_RD1: state <= J_RD2;
        J_RD2: begin
          MonDReg       <= ram_q[31:0];
          monitor_ready <= 1'b1;
          if (cur_inc) MonAReg <= MonAReg + 1'b1;
          state <= IDLE;
        end
        J_WR: begin
          MonAReg       <= MonAReg + 1'b1;
          monitor_ready <= 1'b1;
          state         <= IDLE;
        end
        C_RD1: begin
          readdata <= ram_q[31:0];
          state    <= C_RD2;
        end
        default: state <= IDLE;
      endcase

      if (idle && pend_v) pend_v <= 1'b0;
      if (new_acc && !idle) begin
        pend_v    <= 1'b1;
        pend_wr   <= new_wr;
        pend_inc  <= new_inc;
        pend_data <= jdo[34:3];
      end

      // A fresh address load overrides any same-cycle auto-increment.
      if (addr_load) MonAReg <= jdo[17 +: ADDR_W];
      if (new_acc)   monitor_ready <= 1'b0;
      if (err_clr)   monitor_error <= 1'b0;
      if (collide || drop || par_set) monitor_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_debug_ocimem_ctrl.sv
// tb/tb_debug_ocimem_ctrl.sv - randomized self-checking bench for debug_ocimem_ctrl
module tb_debug_ocimem_ctrl;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [37:0]   jdo;
  logic          take_action_ocimem_a;
  logic          take_no_action_ocimem_a;
  logic          take_action_ocimem_b;
  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic [3:0]    byteenable;
  logic          debugaccess;
  logic [31:0]   readdata;
  logic          waitrequest;
  logic [31:0]   MonDReg;
  logic [AW-1:0] MonAReg;
  logic          monitor_ready;
  logic          monitor_error;

  debug_ocimem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .debugaccess(debugaccess), .readdata(readdata),
    .waitrequest(waitrequest), .MonDReg(MonDReg), .MonAReg(MonAReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0]   ref_mem [256];
  logic [AW-1:0] ref_a;
  logic [31:0]   ref_d;
  logic          ref_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] rand_jdo();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[37:0];
  endfunction

  task automatic pulse(input int which, input logic [37:0] j);
    jdo = j;
    take_action_ocimem_a    = (which == 0);
    take_no_action_ocimem_a = (which == 1);
    take_action_ocimem_b    = (which == 2);
    tick();
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!monitor_ready && n < 50) begin
      tick();
      n++;
    end
    if (!monitor_ready) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic check_mon(input string tag);
    check({tag, "_MonAReg"}, MonAReg, ref_a);
    check({tag, "_MonDReg"}, MonDReg, ref_d);
    check({tag, "_error"}, monitor_error, ref_err);
  endtask

  task automatic jtag_load(input logic [AW-1:0] a, input logic rd);
    logic [37:0] j;
    j = rand_jdo();
    j[35] = 1'b0;
    j[34] = rd;
    j[17 +: AW] = a;
    pulse(0, j);
    ref_a = a;
    if (rd) begin
      wait_ready("load_rd");
      ref_d = ref_mem[a];
      check("load_rd_ready", monitor_ready, 1);
    end
    check_mon("load");
  endtask

  task automatic jtag_write(input logic [31:0] d);
    logic [37:0] j;
    j = rand_jdo();
    j[34:3] = d;
    pulse(2, j);
    wait_ready("jwr");
    ref_mem[ref_a] = d;
    ref_a = ref_a + 1'b1;
    check("jwr_ready", monitor_ready, 1);
    check_mon("jwr");
  endtask

  task automatic jtag_read();
    pulse(1, rand_jdo());
    wait_ready("jrd");
    ref_d = ref_mem[ref_a];
    ref_a = ref_a + 1'b1;
    check_mon("jrd");
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic da);
    int n = 0;
    address = a; writedata = d; byteenable = be; debugaccess = da; write = 1'b1;
    #1;
    while (waitrequest && n < 20) begin
      tick();
      n++;
    end
    if (waitrequest) check("cwr_timeout", 0, 1);
    tick();
    write = 1'b0;
    if (da)
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic cpu_read(input logic [AW-1:0] a);
    int n = 0;
    address = a; read = 1'b1;
    #1;
    while (waitrequest && n < 20) begin
      tick();
      n++;
    end
    if (waitrequest) check("crd_timeout", 0, 1);
    check("crd_latency_ge2", (n >= 2), 1);
    check("crd_data", readdata, ref_mem[a]);
    tick();
    read = 1'b0;
  endtask

  initial begin
    logic [37:0] j;
    int n;
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    address = '0; read = 1'b0; write = 1'b0; writedata = '0; byteenable = '0; debugaccess = 1'b0;
    ref_a = '0; ref_d = '0; ref_err = 1'b0;
    repeat (3) tick();
    check("rst_readdata", readdata, 0);
    check("rst_waitrequest", waitrequest, 1);
    check("rst_ready", monitor_ready, 0);
    check_mon("rst");
    reset_n = 1'b1;
    tick();

    // Fill all of RAM through JTAG so the model is fully known; ends on the wrap to 0.
    jtag_load(8'h00, 1'b0);
    for (int i = 0; i < 256; i++) jtag_write($urandom());
    check("fill_wrap", MonAReg, 8'h00);

    jtag_load(8'h10, 1'b0);
    jtag_write(32'hDEADBEEF);
    check("wr_addr_0x11", MonAReg, 8'h11);
    jtag_load(8'h10, 1'b0);
    jtag_read();
    check("rd_deadbeef", MonDReg, 32'hDEADBEEF);

    jtag_load(8'hFF, 1'b0);
    jtag_write($urandom());
    check("wrap_ff", MonAReg, 8'h00);

    // CPU read collides with a JTAG read on the same cycle.
    jtag_load(8'h10, 1'b0);
    address = 8'h10; read = 1'b1; jdo = rand_jdo(); take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    n = 0;
    while (waitrequest && n < 30) begin
      check("coll_jtag_first", (monitor_ready === 1'b1) || waitrequest, 1);
      tick();
      n++;
    end
    check("coll_waited", waitrequest, 0);
    check("coll_ready", monitor_ready, 1);
    check("coll_readdata", readdata, 32'hDEADBEEF);
    ref_d = 32'hDEADBEEF; ref_a = 8'h11;
    check_mon("coll");
    tick();
    read = 1'b0;

    // Three back-to-back writes: two accepted, the third overflows.
    jtag_load(8'h40, 1'b0);
    for (int k = 0; k < 3; k++) begin
      j = rand_jdo();
      j[34:3] = 32'hA0A0_0000 + k;
      jdo = j;
      take_action_ocimem_b = 1'b1;
      tick();
    end
    take_action_ocimem_b = 1'b0;
    wait_ready("ovf");
    ref_mem[8'h40] = 32'hA0A0_0000; ref_mem[8'h41] = 32'hA0A0_0001;
    ref_a = 8'h42; ref_err = 1'b1;
    check_mon("ovf");
    jtag_load(8'h42, 1'b1);
    j = rand_jdo(); j[35:34] = 2'b11;
    pulse(0, j);
    ref_err = 1'b0;
    check("err_clear", monitor_error, 0);

    // Two strobes at once: the write wins, the read is dropped.
    j = rand_jdo();
    jdo = j;
    take_action_ocimem_b = 1'b1; take_no_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
    wait_ready("strobe_coll");
    ref_mem[ref_a] = j[34:3]; ref_a = ref_a + 1'b1; ref_err = 1'b1;
    check_mon("strobe_coll");
    j = rand_jdo(); j[35:34] = 2'b11;
    pulse(0, j);
    ref_err = 1'b0;
    check("err_clear2", monitor_error, 0);

    cpu_write(8'h20, 32'h12345678, 4'hF, 1'b0);
    cpu_read(8'h20);

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 4))
        0: jtag_load(8'($urandom()), 1'($urandom()));
        1: jtag_write($urandom());
        2: jtag_read();
        3: cpu_write(8'($urandom()), $urandom(), 4'($urandom()), ($urandom_range(0, 3) != 0));
        default: cpu_read(8'($urandom()));
      endcase
    end

    // Reset in the middle of a JTAG read.
    jtag_load(8'h33, 1'b0);
    pulse(1, rand_jdo());
    reset_n = 1'b0;
    #1;
    ref_a = '0; ref_d = '0; ref_err = 1'b0;
    check("mid_rst_ready", monitor_ready, 0);
    check("mid_rst_waitrequest", waitrequest, 1);
    check("mid_rst_readdata", readdata, 0);
    check_mon("mid_rst");
    tick();
    reset_n = 1'b1;
    tick();
    jtag_load(8'h33, 1'b1);
    cpu_read(8'h33);

`ifdef DEBUG_OCIMEM_PARITY_EN
    dut.mem[8'h05][32] = ~dut.mem[8'h05][32];
    ref_err = 1'b1;
    jtag_load(8'h05, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
